// File: rtl/time_domain_register.sv
// -----------------------------------------------------------------------------
// time_domain_register
//
// Stores a time duration V (in clk_i cycles) that is built up by single-unit
// add/subtract strobes, then replays it as a single pulse of exactly V cycles
// on out_o when RE_i rises. Replay does not change V.
//
// Ports
//   clk_i    in   rising-edge clock for all state
//   rstb_i   in   asynchronous active-low reset
//   WE0_i    in   add one time unit per cycle (ignored while replaying)
//   WE1_i    in   remove one time unit per cycle (ignored while replaying)
//   RE_i     in   replay request; a rising edge starts the pulse, holding it
//                 high lets the pulse run, dropping it aborts the pulse
//   carry_o  out  sticky flag: V has wrapped (overflow or borrow) since reset
//   out_o    out  replayed pulse, registered
//
// All inputs other than rstb_i are assumed synchronous to clk_i.
// -----------------------------------------------------------------------------
module time_domain_register #(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rstb_i,
    input  logic WE0_i,
    input  logic WE1_i,
    input  logic RE_i,
    output logic carry_o,
    output logic out_o
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] V_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] V_ZERO = '0;
    localparam logic [WIDTH-1:0] V_ONE  = WIDTH'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [WIDTH-1:0] v_q,       v_d;        // stored duration
    logic [WIDTH-1:0] c_q,       c_d;        // replay countdown
    logic             re_prev_q, re_prev_d;  // RE_i history for edge detect
    logic             out_q,     out_d;
    logic             carry_q,   carry_d;

    logic             re_rise;
    logic             do_add;
    logic             do_sub;

    // -------------------------------------------------------------------------
    // Input decode
    // -------------------------------------------------------------------------
    // Edge history resets to 0, so RE_i held high through reset release is
    // seen as a fresh rising edge on the first sampled cycle.
    assign re_rise = RE_i & ~re_prev_q;

    // Simultaneous add and subtract cancel out.
    assign do_add  = WE0_i & ~WE1_i;
    assign do_sub  = WE1_i & ~WE0_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        c_d       = c_q;
        re_prev_d = RE_i;
        out_d     = 1'b0;
        carry_d   = carry_q;   // sticky: only reset clears it

        unique case (state_q)
            IDLE: begin
                if (do_add) begin
                    v_d = v_q + V_ONE;
                    if (v_q == V_MAX) begin
                        carry_d = 1'b1;
                    end
                end else if (do_sub) begin
                    v_d = v_q - V_ONE;
                    if (v_q == V_ZERO) begin
                        carry_d = 1'b1;
                    end
                end

                // Snapshot the pre-write value; the pulse length is whatever
                // V held when the edge was sampled.
                if (re_rise) begin
                    c_d     = v_q;
                    state_d = READ;
                end
            end

            READ: begin
                // Writes are ignored here so the replayed value is stable.
                if (!RE_i) begin
                    // Abort (or normal exit after the pulse has finished).
                    c_d     = V_ZERO;
                    state_d = IDLE;
                end else if (c_q != V_ZERO) begin
                    out_d = 1'b1;
                    c_d   = c_q - V_ONE;
                end
                // c_q == 0 with RE_i still high: park here with out low until
                // RE_i falls, so a held request cannot retrigger.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q   <= IDLE;
            v_q       <= V_ZERO;
            c_q       <= V_ZERO;
            re_prev_q <= 1'b0;
            out_q     <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            c_q       <= c_d;
            re_prev_q <= re_prev_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
        end
    end

    assign out_o   = out_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_time_domain_register.sv
// -----------------------------------------------------------------------------
// tb_time_domain_register
//
// Self-checking bench for time_domain_register (WIDTH=8). Write stimulus
// updates a simple arithmetic model of V and the carry flag; every read pushes
// the expected pulse (length and start offset) onto a scoreboard queue, which
// is popped and compared once the pulse on out_o has been measured.
// -----------------------------------------------------------------------------
module tb_time_domain_register;

    localparam int WIDTH = 8;
    localparam int V_MOD = 1 << WIDTH;

    logic clk_i;
    logic rstb_i;
    logic WE0_i;
    logic WE1_i;
    logic RE_i;
    logic carry_o;
    logic out_o;

    time_domain_register #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rstb_i  (rstb_i),
        .WE0_i   (WE0_i),
        .WE1_i   (WE1_i),
        .RE_i    (RE_i),
        .carry_o (carry_o),
        .out_o   (out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int len;
        int start;
    } pulse_t;

    pulse_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Bench model of the stored value and carry flag.
    int model_v     = 0;
    int model_carry = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive add/subtract strobes for n cycles, checking carry after each edge.
    task automatic do_write(input bit we0, input bit we1, input int n);
        for (int i = 0; i < n; i++) begin
            WE0_i = we0;
            WE1_i = we1;
            @(posedge clk_i);
            #1;
            if (we0 && !we1) begin
                if (model_v == V_MOD - 1) model_carry = 1;
                model_v = (model_v + 1) % V_MOD;
            end else if (we1 && !we0) begin
                if (model_v == 0) model_carry = 1;
                model_v = (model_v + V_MOD - 1) % V_MOD;
            end
            check_val("carry_write", int'(carry_o), model_carry);
        end
        WE0_i = 1'b0;
        WE1_i = 1'b0;
        $display("write we0=%0b we1=%0b cycles=%0d -> model V=%0d carry=%0d",
                 we0, we1, n, model_v, model_carry);
    endtask

    // Pop the next expected pulse and compare it with what was measured.
    task automatic score(input int highs, input int first, input int last);
        pulse_t e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check_val("pulse_len", highs, e.len);
        check_val("pulse_start", first, e.start);
        check_val("pulse_contig", (highs > 0) ? (last - first + 1) : 0, highs);
        $display("read pulse len=%0d start=%0d (expected len=%0d start=%0d)",
                 highs, first, e.len, e.start);
    endtask

    // Hold RE_i high for n sampled edges, then low for two. When noise is set,
    // WE0_i is driven high while in READ, which must not alter V.
    task automatic do_read(input int n, input bit noise);
        pulse_t e;
        int highs = 0;
        int first = 0;
        int last  = 0;
        e.len   = (model_v < n - 1) ? model_v : n - 1;
        e.start = (e.len > 0) ? 2 : 0;
        exp_q.push_back(e);
        RE_i = 1'b1;
        for (int j = 1; j <= n + 2; j++) begin
            if (j == n + 1) begin
                RE_i  = 1'b0;
                WE0_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            if (out_o === 1'b1) begin
                highs++;
                if (first == 0) first = j;
                last = j;
            end
            if (noise && j == 1) WE0_i = 1'b1;
        end
        score(highs, first, last);
        check_val("carry_read", int'(carry_o), model_carry);
    endtask

    // Asynchronous reset pulse asserted mid-cycle.
    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rstb_i = 1'b0;
        #1;
        check_val("rst_out", int'(out_o), 0);
        check_val("rst_carry", int'(carry_o), 0);
        @(negedge clk_i);
        rstb_i      = 1'b1;
        model_v     = 0;
        model_carry = 0;
    endtask

    initial begin
        pulse_t e;
        int highs;
        int first;
        int last;

        rstb_i = 1'b1;
        WE0_i  = 1'b1;
        WE1_i  = 1'b0;
        RE_i   = 1'b1;

        // Reset with RE and WE0 high: outputs clear before any clock edge.
        #2;
        rstb_i = 1'b0;
        #1;
        check_val("init_rst_out", int'(out_o), 0);
        check_val("init_rst_carry", int'(carry_o), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        WE0_i  = 1'b0;
        rstb_i = 1'b1;   // RE_i still high across release
        e.len   = 0;
        e.start = 0;
        exp_q.push_back(e);
        highs = 0; first = 0; last = 0;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk_i);
            #1;
            if (out_o === 1'b1) begin
                highs++;
                if (first == 0) first = j;
                last = j;
            end
        end
        RE_i = 1'b0;
        @(posedge clk_i);
        #1;
        score(highs, first, last);
        check_val("carry_after_rst", int'(carry_o), 0);

        // Write 5, read with RE held 10 cycles.
        do_write(1'b1, 1'b0, 5);
        do_read(10, 1'b0);

        // Add 5, subtract 2, read twice; writes during READ are ignored.
        do_reset();
        do_write(1'b1, 1'b0, 5);
        do_write(1'b0, 1'b1, 2);
        do_read(8, 1'b0);
        do_read(8, 1'b0);
        do_read(8, 1'b1);
        do_read(8, 1'b0);

        // Overflow: 260 increments wrap to 4 and set carry.
        do_reset();
        do_write(1'b1, 1'b0, 260);
        do_read(8, 1'b0);

        // Simultaneous strobes cancel, then a borrow from 0.
        do_reset();
        do_write(1'b1, 1'b1, 3);
        do_read(4, 1'b0);
        do_write(1'b0, 1'b1, 1);
        do_read(260, 1'b0);

        // Abort: V=20, RE high for 6 cycles gives a 5-cycle pulse.
        do_reset();
        do_write(1'b1, 1'b0, 20);
        do_read(6, 1'b0);

        // Reset mid-pulse forces out_o low without a clock edge, clears V.
        RE_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        check_val("mid_pulse_out", int'(out_o), 1);
        #2;
        rstb_i = 1'b0;
        #1;
        check_val("mid_pulse_rst_out", int'(out_o), 0);
        RE_i = 1'b0;
        @(negedge clk_i);
        rstb_i      = 1'b1;
        model_v     = 0;
        model_carry = 0;
        $display("reset asserted mid-pulse");
        do_read(25, 1'b0);

        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
